// File: rtl/wall_datapath.sv
// wall_datapath: owns the wall's position and gap, steps it left per frame tick and paints columns into the VGA writer.
// Ports: clk/resetn (sync, active-low); init starts a new wall at the right edge with gap top gap_y;
// move permits stepping; player_y is tested against the wall after each step.
// vga_x/vga_y/colour/plot form the pixel write stream; touched pulses on collision, passed when the wall
// leaves the screen; busy is high outside IDLE.
module wall_datapath #(
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120,
  parameter int WALL_W = 4,
  parameter int GAP_H = 30,
  parameter int TICK_DIV = 833333,
  parameter int PLAYER_X = 20,
  parameter int PLAYER_W = 4,
  parameter int PLAYER_H = 4,
  parameter logic [2:0] BG_COLOUR = 3'b000,
  parameter logic [2:0] WALL_COLOUR = 3'b010
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       init,
  input  logic       move,
  input  logic [6:0] gap_y,
  input  logic [6:0] player_y,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] colour,
  output logic       plot,
  output logic       touched,
  output logic       passed,
  output logic       busy
);
  localparam int TW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  localparam int CW = WALL_W > 1 ? $clog2(WALL_W) : 1;
  typedef enum logic [2:0] {IDLE, INIT_DRAW, WAIT_TICK, ERASE, DRAW, CHECK, CLEAR} state_t;
  state_t state_q, state_d;
  logic [7:0] wx_q, wx_d;
  logic [6:0] gy_q, gy_d, ycnt_q, ycnt_d;
  logic [CW-1:0] ccnt_q, ccnt_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [8:0] wx9, gy9, py9, y9;
  logic col_end, scan_end, multi, tick, in_gap, hov, vout, hit, gap_over, painted;
  assign wx9 = {1'b0, wx_q};
  assign gy9 = {2'b0, gy_q};
  assign py9 = {2'b0, player_y};
  assign y9 = {2'b0, ycnt_q};
  assign col_end = ycnt_q == 7'(SCREEN_H - 1);
  assign scan_end = col_end && ccnt_q == CW'(WALL_W - 1);
  assign multi = state_q == INIT_DRAW || state_q == CLEAR;
  assign tick = tcnt_q == TW'(TICK_DIV - 1);
  assign in_gap = y9 >= gy9 && y9 <= gy9 + 9'(GAP_H - 1);
  assign hov = wx9 <= 9'(PLAYER_X + PLAYER_W - 1) && wx9 + 9'(WALL_W - 1) >= 9'(PLAYER_X);
  assign vout = py9 < gy9 || py9 + 9'(PLAYER_H - 1) > gy9 + 9'(GAP_H - 1);
  assign hit = state_q == CHECK && hov && vout;
  assign gap_over = {2'b0, gap_y} + 9'(GAP_H) > 9'(SCREEN_H);
  // wall columns (initial draw and new leading column) carry the gap; erase/clear are solid background
  assign painted = state_q == INIT_DRAW || state_q == DRAW;
  assign plot = multi || state_q == ERASE || state_q == DRAW;
  assign vga_y = plot ? ycnt_q : '0;
  assign vga_x = state_q == INIT_DRAW ? wx_q + 8'(ccnt_q) :
                 state_q == ERASE ? wx_q + 8'(WALL_W - 1) :
                 state_q == DRAW ? wx_q :
                 state_q == CLEAR ? 8'(ccnt_q) : '0;
  assign colour = !plot ? '0 : painted && !in_gap ? WALL_COLOUR : BG_COLOUR;
  assign touched = hit;
  assign passed = state_q == CLEAR && scan_end;
  assign busy = state_q != IDLE;
  always_comb begin
    state_d = state_q;
    wx_d = wx_q;
    gy_d = gy_q;
    ycnt_d = plot ? (col_end ? '0 : ycnt_q + 7'd1) : ycnt_q;
    ccnt_d = multi && col_end ? (scan_end ? '0 : ccnt_q + CW'(1)) : ccnt_q;
    tcnt_d = tcnt_q;
    if (init) begin
      state_d = INIT_DRAW;
      wx_d = 8'(SCREEN_W - WALL_W);
      gy_d = gap_over ? 7'(SCREEN_H - GAP_H) : gap_y;
      ycnt_d = '0;
      ccnt_d = '0;
      tcnt_d = '0;
    end else begin
      case (state_q)
        INIT_DRAW: if (scan_end) state_d = WAIT_TICK;
        WAIT_TICK: if (move) begin
          tcnt_d = tick ? '0 : tcnt_q + TW'(1);
          if (tick) state_d = wx_q == '0 ? CLEAR : ERASE;
        end
        ERASE: if (col_end) begin
          wx_d = wx_q - 8'd1;
          state_d = DRAW;
        end
        DRAW: if (col_end) state_d = CHECK;
        CHECK: state_d = hit ? IDLE : WAIT_TICK;
        CLEAR: if (scan_end) state_d = IDLE;
        default: ;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= IDLE;
      wx_q <= 8'(SCREEN_W - WALL_W);
      gy_q <= '0;
      ycnt_q <= '0;
      ccnt_q <= '0;
      tcnt_q <= '0;
    end else begin
      state_q <= state_d;
      wx_q <= wx_d;
      gy_q <= gy_d;
      ycnt_q <= ycnt_d;
      ccnt_q <= ccnt_d;
      tcnt_q <= tcnt_d;
    end
  end
endmodule

// File: tb/tb_wall_datapath.sv
// tb_wall_datapath: randomized self-checking bench for wall_datapath against a pixel-stream reference model.
module tb_wall_datapath;
  localparam int SW = 16, SH = 8, WW = 2, GH = 3, TD = 4, PX = 2, PW = 1, PH = 1;
  localparam int BG = 0, WC = 2;
  logic clk = 0, resetn = 0, init = 0, move = 0;
  logic [6:0] gap_y = 0, player_y = 0;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] colour;
  logic plot, touched, passed, busy;
  int checks = 0, failures = 0, cyc = 0;
  typedef struct {int x; int y; int c; int t;} pix_t;
  pix_t got[$], exp_q[$];
  int touch_t[$], pass_t[$];
  wall_datapath #(.SCREEN_W(SW), .SCREEN_H(SH), .WALL_W(WW), .GAP_H(GH), .TICK_DIV(TD),
    .PLAYER_X(PX), .PLAYER_W(PW), .PLAYER_H(PH), .BG_COLOUR(3'b000), .WALL_COLOUR(3'b010)) dut (
    .clk(clk), .resetn(resetn), .init(init), .move(move), .gap_y(gap_y), .player_y(player_y),
    .vga_x(vga_x), .vga_y(vga_y), .colour(colour), .plot(plot), .touched(touched), .passed(passed), .busy(busy));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (plot === 1'b1) got.push_back('{int'(vga_x), int'(vga_y), int'(colour), cyc});
    if (touched === 1'b1) touch_t.push_back(cyc);
    if (passed === 1'b1) pass_t.push_back(cyc);
  end
  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  task automatic step(int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic clear_logs();
    got.delete(); exp_q.delete(); touch_t.delete(); pass_t.delete();
  endtask
  task automatic do_reset();
    resetn = 0; init = 0; move = 0;
    step(2);
    resetn = 1;
    clear_logs();
  endtask
  task automatic pulse_init(int g);
    gap_y = 7'(g); init = 1;
    step(1);
    init = 0;
  endtask
  function automatic int clampg(int g);
    return g + GH > SH ? SH - GH : g;
  endfunction
  function automatic void add_col(int x, int g, bit bg_only);
    for (int y = 0; y < SH; y++)
      exp_q.push_back('{x, y, (bg_only || (y >= g && y <= g + GH - 1)) ? BG : WC, 0});
  endfunction
  function automatic bit hit(int wx, int g, int py);
    return wx <= PX + PW - 1 && wx + WW - 1 >= PX && (py < g || py + PH - 1 > g + GH - 1);
  endfunction
  // index of the first expected pixel not matched (value or back-to-back timing within a 16-pixel burst), -1 if all match
  function automatic int first_diff(int base);
    for (int i = 0; i < exp_q.size(); i++) begin
      if (base + i >= got.size()) return i;
      if (got[base+i].x != exp_q[i].x || got[base+i].y != exp_q[i].y || got[base+i].c != exp_q[i].c) return i;
      if (i % (2 * SH) != 0 && got[base+i].t != got[base+i-1].t + 1) return i;
    end
    return -1;
  endfunction
  task automatic wait_plots(int n, int budget, string name);
    int k = 0;
    while (got.size() < n && k < budget) begin step(1); k++; end
    checks++;
    if (got.size() < n) begin
      failures++;
      $display("FAIL %s_timeout: plots=%0d required=%0d", name, got.size(), n);
    end
  endtask
  task automatic test_reset();
    int n;
    resetn = 0; init = 0; move = 0;
    step(2);
    checks++;
    if ({plot, vga_x, vga_y, colour, touched, passed, busy} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: plot=%b x=%0d y=%0d c=%0d t=%b p=%b busy=%b required all 0",
        plot, vga_x, vga_y, colour, touched, passed, busy);
    end
    resetn = 1;
    clear_logs();
    step(10);
    checks++;
    if (got.size() != 0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL idle_quiet: plots=%0d busy=%b required 0 and 0", got.size(), busy);
    end
    pulse_init(2);
    step(5);
    resetn = 0;
    step(1);
    checks++;
    if ({plot, touched, passed, busy} !== 4'b0) begin
      failures++;
      $display("FAIL reset_midscan: plot=%b t=%b p=%b busy=%b required 0", plot, touched, passed, busy);
    end
    resetn = 1;
    n = got.size();
    step(20);
    checks++;
    if (got.size() != n) begin
      failures++;
      $display("FAIL reset_no_resume: plots=%0d required=%0d", got.size(), n);
    end
  endtask
  task automatic test_init_draw();
    int gaps[3];
    int d;
    gaps = '{2, 6, int'($urandom_range(0, SH))};
    foreach (gaps[j]) begin
      do_reset();
      pulse_init(gaps[j]);
      wait_plots(WW * SH, 40, "init_draw");
      add_col(SW - WW, clampg(gaps[j]), 0);
      add_col(SW - WW + 1, clampg(gaps[j]), 0);
      d = first_diff(0);
      checks++;
      if (d != -1) begin
        failures++;
        $display("FAIL init_draw gap=%0d: first bad pixel=%0d required none (plots=%0d)", gaps[j], d, got.size());
      end
      step(30);
      checks++;
      if (got.size() != WW * SH || busy !== 1'b1) begin
        failures++;
        $display("FAIL hold_no_move: plots=%0d busy=%b required %0d and 1", got.size(), busy, WW * SH);
      end
    end
  endtask
  task automatic test_step();
    int g, t0, d;
    do_reset();
    g = $urandom_range(0, SH - GH);
    pulse_init(g);
    wait_plots(16, 40, "step_init");
    step(3);
    t0 = cyc;
    move = 1;
    wait_plots(48, 100, "step_two");
    checks++;
    if (got[16].t - t0 != TD) begin
      failures++;
      $display("FAIL step_latency: got=%0d required=%0d", got[16].t - t0, TD);
    end
    checks++;
    if (got[32].t - got[16].t != TD + 2 * SH + 1) begin
      failures++;
      $display("FAIL step_period: got=%0d required=%0d", got[32].t - got[16].t, TD + 2 * SH + 1);
    end
    wait_plots(51, 40, "step_third");
    move = 0;
    wait_plots(64, 40, "step_finish");
    step(40);
    checks++;
    if (got.size() != 64 || busy !== 1'b1) begin
      failures++;
      $display("FAIL move_drop_hold: plots=%0d busy=%b required 64 and 1", got.size(), busy);
    end
    for (int w = SW - WW; w > SW - WW - 3; w--) begin
      add_col(w + WW - 1, 0, 1);
      add_col(w - 1, g, 0);
    end
    d = first_diff(16);
    checks++;
    if (d != -1) begin
      failures++;
      $display("FAIL step_stream gap=%0d: first bad pixel=%0d required none", g, d);
    end
  endtask
  task automatic run_game(int g, int py, string name);
    int k = 0, wx, cg, d, n;
    bit want_touch = 0, want_pass = 0;
    do_reset();
    player_y = 7'(py);
    pulse_init(g);
    move = 1;
    while (busy === 1'b1 && k < 1000) begin step(1); k++; end
    move = 0;
    cg = clampg(g);
    add_col(SW - WW, cg, 0);
    add_col(SW - WW + 1, cg, 0);
    wx = SW - WW;
    forever begin
      if (wx == 0) begin
        for (int c = 0; c < WW; c++) add_col(c, 0, 1);
        want_pass = 1;
        break;
      end
      add_col(wx + WW - 1, 0, 1);
      wx--;
      add_col(wx, cg, 0);
      if (hit(wx, cg, py)) begin want_touch = 1; break; end
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL %s_end: busy=%b required 0", name, busy);
    end
    d = first_diff(0);
    checks++;
    if (d != -1 || got.size() != exp_q.size()) begin
      failures++;
      $display("FAIL %s_stream g=%0d py=%0d: first bad=%0d plots=%0d required %0d", name, g, py, d, got.size(), exp_q.size());
    end
    checks++;
    if (touch_t.size() != int'(want_touch) || pass_t.size() != int'(want_pass)) begin
      failures++;
      $display("FAIL %s_pulses g=%0d py=%0d: touched=%0d passed=%0d required %0d %0d",
        name, g, py, touch_t.size(), pass_t.size(), want_touch, want_pass);
    end else if (got.size() > 0) begin
      checks++;
      if (want_touch && touch_t[0] != got[got.size()-1].t + 1 || want_pass && pass_t[0] != got[got.size()-1].t) begin
        failures++;
        $display("FAIL %s_pulse_time: touch=%p pass=%p last_plot=%0d", name, touch_t, pass_t, got[got.size()-1].t);
      end
    end
    n = got.size();
    step(20);
    checks++;
    if (got.size() != n) begin
      failures++;
      $display("FAIL %s_quiet: plots=%0d required=%0d", name, got.size(), n);
    end
  endtask
  task automatic test_games();
    run_game(2, 0, "touch");
    run_game(2, 3, "pass");
    for (int r = 0; r < 6; r++) run_game($urandom_range(0, SH), $urandom_range(0, SH - 1), "random");
  endtask
  task automatic test_init_mid_erase();
    int g2, d;
    do_reset();
    pulse_init(2);
    wait_plots(16, 40, "mid_init");
    move = 1;
    wait_plots(19, 40, "mid_erase");
    g2 = $urandom_range(3, SH);
    gap_y = 7'(g2);
    init = 1;
    step(1);
    init = 0;
    wait_plots(36, 40, "mid_redraw");
    move = 0;
    checks++;
    if (got[19].x != SW - 1 || got[19].c != BG || got[20].t != got[19].t + 1) begin
      failures++;
      $display("FAIL mid_handover: x=%0d c=%0d dt=%0d required %0d %0d 1", got[19].x, got[19].c, got[20].t - got[19].t, SW - 1, BG);
    end
    add_col(SW - WW, clampg(g2), 0);
    add_col(SW - WW + 1, clampg(g2), 0);
    d = first_diff(20);
    checks++;
    if (d != -1) begin
      failures++;
      $display("FAIL mid_redraw gap=%0d: first bad pixel=%0d required none", g2, d);
    end
  endtask
  initial begin
    test_reset();
    test_init_draw();
    test_step();
    test_games();
    test_init_mid_erase();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
